// File: rtl/dfreq_serial_tx_pkg.sv
// Shared types and constants for the dual-frequency serial transmitter.
package dfreq_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/dfreq_serial_tx_if.sv
// Control/status bundle between the register layer and the serializer.
interface dfreq_serial_tx_if #(
    parameter int DATA_BIT = 32,
    parameter int CNT_W    = 8,
    parameter int RPT_W    = 8
) ();

    logic                i_start;
    logic                i_stop;
    logic                i_msb_first;
    logic                i_idle_level;
    logic [RPT_W-1:0]    i_repeat_cnt;
    logic [CNT_W-1:0]    i_high_period;
    logic [CNT_W-1:0]    i_low_period;
    logic [DATA_BIT-1:0] i_output_pattern;
    logic [DATA_BIT-1:0] i_freq_pattern;
    logic                o_serial_out;
    logic                o_busy;
    logic                o_bit_tick;
    logic                o_done_tick;
    logic                o_finish_tick;

    modport master (
        output i_start, i_stop, i_msb_first, i_idle_level, i_repeat_cnt,
               i_high_period, i_low_period, i_output_pattern, i_freq_pattern,
        input  o_serial_out, o_busy, o_bit_tick, o_done_tick, o_finish_tick
    );

    modport slave (
        input  i_start, i_stop, i_msb_first, i_idle_level, i_repeat_cnt,
               i_high_period, i_low_period, i_output_pattern, i_freq_pattern,
        output o_serial_out, o_busy, o_bit_tick, o_done_tick, o_finish_tick
    );

endinterface

// File: rtl/dfreq_serial_tx_period_cnt.sv
// Per-bit period down-counter: loads P-1 (a period of 0 counts as 1) and flags expiry at zero.
module dfreq_period_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (period_i == '0) ? '0 : period_i - 1'b1;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/dfreq_serial_tx.sv
// Serializer that holds each pattern bit for a high or low period chosen by a per-bit select pattern.
//
// state  | meaning
// S_IDLE | output follows sampled idle level, waiting for start
// S_RUN  | shifting out the latched pattern, pass after pass
module dfreq_serial_tx
    import dfreq_pkg::*;
#(
    parameter int DATA_BIT = 32,
    parameter int CNT_W    = 8,
    parameter int RPT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    dfreq_serial_tx_if.slave bus
);

    localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);

    state_e              state_q, state_d;
    logic [DATA_BIT-1:0] pat_q, pat_d;
    logic [DATA_BIT-1:0] freq_q, freq_d;
    logic [CNT_W-1:0]    hi_q, hi_d;
    logic [CNT_W-1:0]    lo_q, lo_d;
    logic                msb_q, msb_d;
    logic                idle_q, idle_d;
    logic [RPT_W-1:0]    rpt_q, rpt_d;
    logic [RPT_W-1:0]    pass_q, pass_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                serial_q, serial_d;
    logic                busy_q, busy_d;
    logic                bit_tick_q, bit_tick_d;
    logic                done_tick_q, done_tick_d;
    logic                finish_tick_q, finish_tick_d;

    logic                launch;
    logic                load_bit;
    logic                cnt_clr;
    logic                expire;
    logic [IDX_W-1:0]    bit_pos;
    logic [CNT_W-1:0]    cnt_val;
    logic [RPT_W:0]      pass_inc;

    dfreq_period_cnt #(
        .CNT_W (CNT_W)
    ) u_period_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_bit),
        .clr_i    (cnt_clr),
        .en_i     (state_q == S_RUN),
        .period_i (cnt_val),
        .expire_o (expire)
    );

    always_comb begin
        state_d       = state_q;
        pat_d         = pat_q;
        freq_d        = freq_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        msb_d         = msb_q;
        idle_d        = idle_q;
        rpt_d         = rpt_q;
        pass_d        = pass_q;
        idx_d         = idx_q;
        serial_d      = serial_q;
        busy_d        = busy_q;
        bit_tick_d    = 1'b0;
        done_tick_d   = 1'b0;
        finish_tick_d = 1'b0;
        launch        = 1'b0;
        load_bit      = 1'b0;
        cnt_clr       = 1'b0;
        pass_inc      = {1'b0, pass_q} + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                idle_d   = bus.i_idle_level;
                serial_d = bus.i_idle_level;
                busy_d   = 1'b0;
                cnt_clr  = 1'b1;
                if (bus.i_start) begin
                    launch = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.i_stop) begin
                    state_d  = S_IDLE;
                    serial_d = idle_q;
                    busy_d   = 1'b0;
                    cnt_clr  = 1'b1;
                end else if (bus.i_start) begin
                    launch = 1'b1;
                end else if (expire) begin
                    bit_tick_d = 1'b1;
                    if (idx_q != LAST_IDX) begin
                        idx_d    = idx_q + 1'b1;
                        load_bit = 1'b1;
                    end else begin
                        done_tick_d = 1'b1;
                        if (rpt_q != '0 && pass_q != '1) begin
                            pass_d = pass_q + 1'b1;
                        end
                        // A zero repeat count never finishes; otherwise stop once enough passes are done.
                        if (rpt_q != '0 && pass_inc >= {1'b0, rpt_q}) begin
                            state_d       = S_IDLE;
                            serial_d      = idle_q;
                            busy_d        = 1'b0;
                            finish_tick_d = 1'b1;
                            cnt_clr       = 1'b1;
                        end else begin
                            idx_d    = '0;
                            load_bit = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            pat_d    = bus.i_output_pattern;
            freq_d   = bus.i_freq_pattern;
            hi_d     = bus.i_high_period;
            lo_d     = bus.i_low_period;
            msb_d    = bus.i_msb_first;
            idle_d   = bus.i_idle_level;
            rpt_d    = bus.i_repeat_cnt;
            pass_d   = '0;
            idx_d    = '0;
            state_d  = S_RUN;
            busy_d   = 1'b1;
            load_bit = 1'b1;
        end

        // Bit and period come from the *_d copies so a fresh start uses the just-latched config.
        bit_pos = (msb_d == MSB_FIRST) ? (LAST_IDX - idx_d) : idx_d;
        cnt_val = freq_d[bit_pos] ? hi_d : lo_d;
        if (load_bit) begin
            serial_d = pat_d[bit_pos];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pat_q         <= '0;
            freq_q        <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            msb_q         <= 1'b0;
            idle_q        <= 1'b0;
            rpt_q         <= '0;
            pass_q        <= '0;
            idx_q         <= '0;
            serial_q      <= 1'b0;
            busy_q        <= 1'b0;
            bit_tick_q    <= 1'b0;
            done_tick_q   <= 1'b0;
            finish_tick_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pat_q         <= pat_d;
            freq_q        <= freq_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            msb_q         <= msb_d;
            idle_q        <= idle_d;
            rpt_q         <= rpt_d;
            pass_q        <= pass_d;
            idx_q         <= idx_d;
            serial_q      <= serial_d;
            busy_q        <= busy_d;
            bit_tick_q    <= bit_tick_d;
            done_tick_q   <= done_tick_d;
            finish_tick_q <= finish_tick_d;
        end
    end

    assign bus.o_serial_out  = serial_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_bit_tick    = bit_tick_q;
    assign bus.o_done_tick   = done_tick_q;
    assign bus.o_finish_tick = finish_tick_q;

endmodule

// File: tb/tb_dfreq_serial_tx.sv
// Directed and randomized checks of dfreq_serial_tx against a cycle-list waveform model.
module tb_dfreq_serial_tx;

    localparam int DW = 8;

    typedef struct packed {
        logic [7:0] pat;
        logic [7:0] freq;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] rpt;
        logic       msb;
        logic       idle;
    } cfg_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    // Each entry: {serial, busy, bit_tick, done_tick, finish_tick} for one cycle after start.
    logic [4:0] exp_q[$];

    dfreq_serial_tx_if #(.DATA_BIT(DW), .CNT_W(8), .RPT_W(8)) bus ();

    dfreq_serial_tx #(.DATA_BIT(DW), .CNT_W(8), .RPT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic int bit_period(input cfg_t c, input int k);
        int pos;
        int per;
        pos = c.msb ? (DW - 1 - k) : k;
        per = c.freq[pos] ? int'(c.hi) : int'(c.lo);
        if (per == 0) per = 1;
        return per;
    endfunction

    function automatic int prefix_len(input cfg_t c, input int nbits);
        int s;
        s = 0;
        for (int k = 0; k < nbits; k++) s += bit_period(c, k);
        return s;
    endfunction

    // Waveform after a start: passes of bits, each held for its period; maxn>0 truncates.
    task automatic model_tx(input cfg_t c, input int maxn);
        int p;
        int pos;
        int per;
        exp_q.delete();
        p = 1;
        while (1) begin
            if (c.rpt != 0 && p > int'(c.rpt)) begin
                exp_q.push_back({c.idle, 1'b0, 1'b1, 1'b1, 1'b1});
                for (int t = 0; t < 3; t++) exp_q.push_back({c.idle, 4'b0000});
                break;
            end
            if (maxn > 0 && exp_q.size() >= maxn) break;
            for (int k = 0; k < DW; k++) begin
                pos = c.msb ? (DW - 1 - k) : k;
                per = bit_period(c, k);
                for (int j = 0; j < per; j++)
                    exp_q.push_back({c.pat[pos], 1'b1, (j == 0) && (k > 0 || p > 1),
                                     (j == 0) && (k == 0) && (p > 1), 1'b0});
            end
            p++;
        end
        while (maxn > 0 && exp_q.size() > maxn) void'(exp_q.pop_back());
    endtask

    function automatic cfg_t rand_cfg(input int pmin, input int pmax);
        cfg_t c;
        c.pat  = 8'($urandom);
        c.freq = 8'($urandom);
        c.hi   = 8'($urandom_range(pmax, pmin));
        c.lo   = 8'($urandom_range(pmax, pmin));
        c.rpt  = 8'd1;
        c.msb  = 1'($urandom);
        c.idle = 1'($urandom);
        return c;
    endfunction

    task automatic apply_cfg(input cfg_t c);
        bus.i_output_pattern = c.pat;
        bus.i_freq_pattern   = c.freq;
        bus.i_high_period    = c.hi;
        bus.i_low_period     = c.lo;
        bus.i_repeat_cnt     = c.rpt;
        bus.i_msb_first      = c.msb;
        bus.i_idle_level     = c.idle;
    endtask

    task automatic go(input cfg_t c);
        apply_cfg(c);
        bus.i_start = 1'b1;
    endtask

    task automatic check_now(input string tag, input logic [4:0] expv);
        logic [4:0] obs;
        obs = {bus.o_serial_out, bus.o_busy, bus.o_bit_tick, bus.o_done_tick, bus.o_finish_tick};
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // One comparison per cycle; pulses are dropped after the first sample. Scramble proves inputs are latched.
    task automatic check_q(input string tag, input bit scramble);
        logic [4:0] obs;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            obs = {bus.o_serial_out, bus.o_busy, bus.o_bit_tick, bus.o_done_tick, bus.o_finish_tick};
            n_cmp++;
            assert (obs === exp_q[i]) else begin
                n_fail++;
                $error("FAIL %s cyc %0d: observed %b expected %b", tag, i, obs, exp_q[i]);
            end
            bus.i_start = 1'b0;
            bus.i_stop  = 1'b0;
            if (scramble) begin
                bus.i_output_pattern = 8'($urandom);
                bus.i_freq_pattern   = 8'($urandom);
                bus.i_high_period    = 8'($urandom);
                bus.i_low_period     = 8'($urandom);
                bus.i_repeat_cnt     = 8'($urandom);
                bus.i_msb_first      = 1'($urandom);
            end
        end
    endtask

    initial begin
        cfg_t c;
        cfg_t n;
        int   s;
        n_cmp  = 0;
        n_fail = 0;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        apply_cfg('{pat: 8'h00, freq: 8'h00, hi: 8'd0, lo: 8'd0, rpt: 8'd0, msb: 1'b0, idle: 1'b1});
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_now("reset", 5'b00000);
        rst_n = 1'b1;
        @(negedge clk);
        check_now("idle_after_reset", 5'b10000);

        // Basic LSB-first single pass
        c = '{pat: 8'hA5, freq: 8'h0F, hi: 8'd2, lo: 8'd4, rpt: 8'd1, msb: 1'b0, idle: 1'b0};
        model_tx(c, 0);
        go(c);
        check_q("lsb_pass", 1'b0);

        // MSB-first, three passes, inputs scrambled while running
        c = '{pat: 8'hA5, freq: 8'h0F, hi: 8'd2, lo: 8'd4, rpt: 8'd3, msb: 1'b1, idle: 1'b1};
        model_tx(c, 0);
        go(c);
        check_q("msb_x3", 1'b1);
        apply_cfg(c);

        bus.i_stop = 1'b1;
        exp_q = '{5'b10000, 5'b10000};
        check_q("stop_in_idle", 1'b0);

        // Infinite repeat, stop mid-bit in pass 5
        c = rand_cfg(2, 4);
        c.rpt = 8'd0;
        s = 4 * prefix_len(c, DW) + 1;
        model_tx(c, s + 1);
        go(c);
        check_q("rpt0_run", 1'b0);
        bus.i_stop = 1'b1;
        exp_q = '{{c.idle, 4'b0000}, {c.idle, 4'b0000}, {c.idle, 4'b0000}};
        check_q("stop_mid", 1'b0);

        // Restart during bit 3
        c = rand_cfg(2, 4);
        c.rpt = 8'd2;
        model_tx(c, prefix_len(c, 3) + 2);
        go(c);
        check_q("pre_restart", 1'b0);
        n = '{pat: 8'hFF, freq: 8'h00, hi: 8'($urandom_range(9, 1)), lo: 8'd1, rpt: 8'd1,
              msb: 1'($urandom), idle: c.idle};
        model_tx(n, 0);
        go(n);
        check_q("restart", 1'b0);

        // High period of zero acts as one
        c = rand_cfg(1, 3);
        c.hi  = 8'd0;
        c.rpt = 8'd2;
        model_tx(c, 0);
        go(c);
        check_q("high_zero", 1'b0);

        // Randomized configurations, including zero periods
        for (int r = 0; r < 4; r++) begin
            c = rand_cfg(0, 5);
            c.rpt = 8'($urandom_range(3, 1));
            model_tx(c, 0);
            go(c);
            check_q("random", 1'b0);
        end

        // Start and stop together while running: stop wins
        c = rand_cfg(1, 4);
        c.rpt = 8'd0;
        model_tx(c, 10);
        go(c);
        check_q("pre_startstop", 1'b0);
        n = rand_cfg(1, 4);
        n.idle = c.idle;
        apply_cfg(n);
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        exp_q = '{{c.idle, 4'b0000}, {c.idle, 4'b0000}, {c.idle, 4'b0000}};
        check_q("startstop", 1'b0);

        // Reset mid-run
        c = rand_cfg(1, 4);
        c.rpt  = 8'd0;
        c.idle = 1'b1;
        model_tx(c, 6);
        go(c);
        check_q("pre_reset", 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_now("reset_mid_run", 5'b00000);
        rst_n = 1'b1;
        @(negedge clk);
        check_now("idle_after_mid_reset", 5'b10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
